// File: rtl/bus_master_rr.sv
// rtl/bus_master_rr.sv - round-robin local bus master with grant timeout, backoff and retry; optional ACK_TIMEOUT_EN adds a GRANTED ack timeout
module bus_master_rr #(
  parameter int NUM_SRC     = 4,
  parameter int REQ_TIMEOUT = 16,
  parameter int BACKOFF_CYC = 4,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 64,
  localparam int OWNER_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               bus_grant,
  input  logic               bus_ack,
  output logic               bus_req,
  output logic [NUM_SRC-1:0] src_done,
  output logic [NUM_SRC-1:0] src_err,
  output logic [OWNER_W-1:0] owner_id,
  output logic               busy
);

  // Counter widths sized to the largest value each counter ever holds.
  localparam int WAIT_W  = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BO_W    = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;

  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(REQ_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [BO_W-1:0]    BO_LAST   = BO_W'(BACKOFF_CYC - 1);

`ifdef ACK_TIMEOUT_EN
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_BACKOFF = 2'd2,
    S_GRANT   = 2'd3
  } state_e;

  state_e               state_q;
  logic                 bus_req_q;
  logic [NUM_SRC-1:0]   src_done_q;
  logic [NUM_SRC-1:0]   src_err_q;
  logic [OWNER_W-1:0]   owner_q;
  logic                 busy_q;
  logic [OWNER_W-1:0]   rr_ptr_q;
  logic [WAIT_W-1:0]    wait_cnt_q;
  logic [RETRY_W-1:0]   retry_cnt_q;
  logic [BO_W-1:0]      bo_cnt_q;
`ifdef ACK_TIMEOUT_EN
  logic [ACK_W-1:0]     ack_cnt_q;
`endif

  logic                 pick_vld;
  logic [OWNER_W-1:0]   pick_idx;
  logic [OWNER_W-1:0]   rr_ptr_d;
  logic [NUM_SRC-1:0]   owner_onehot;
  logic                 owner_req;

  // (base + off) mod NUM_SRC, with off < NUM_SRC so one subtraction suffices.
  function automatic logic [OWNER_W-1:0] rot_idx(input logic [OWNER_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) begin
      s = s - NUM_SRC;
    end
    return OWNER_W'(s);
  endfunction

  assign rr_ptr_d     = rot_idx(owner_q, 1);
  assign owner_onehot = NUM_SRC'(1) << owner_q;
  assign owner_req    = src_req[owner_q];

  // Round-robin pick: first requesting source at or after rr_ptr, wrapping; the lowest offset wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_req[rot_idx(rr_ptr_q, i)]) begin
        pick_vld = 1'b1;
        pick_idx = rot_idx(rr_ptr_q, i);
      end
    end
  end

  // Main sequencer: owner selection, request/backoff/retry timing and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      src_done_q  <= '0;
      src_err_q   <= '0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      rr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      retry_cnt_q <= '0;
      bo_cnt_q    <= '0;
`ifdef ACK_TIMEOUT_EN
      ack_cnt_q   <= '0;
`endif
    end else begin
      src_done_q <= '0;
      src_err_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            owner_q     <= pick_idx;
            wait_cnt_q  <= '0;
            retry_cnt_q <= '0;
            state_q     <= S_REQ;
            bus_req_q   <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        S_REQ: begin
          if (bus_grant) begin
            // Grant beats both a same-cycle cancel and a same-cycle timeout.
            state_q   <= S_GRANT;
            bus_req_q <= 1'b0;
`ifdef ACK_TIMEOUT_EN
            ack_cnt_q <= '0;
`endif
          end else if (!owner_req) begin
            // Cancel: silent return, rr_ptr untouched.
            state_q   <= S_IDLE;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            bus_req_q <= 1'b0;
            if (retry_cnt_q < RETRY_MAX) begin
              state_q     <= S_BACKOFF;
              retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
              bo_cnt_q    <= '0;
            end else begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              src_err_q <= owner_onehot;
              rr_ptr_q  <= rr_ptr_d;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end

        S_BACKOFF: begin
          if (!owner_req) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (bo_cnt_q == BO_LAST) begin
            state_q    <= S_REQ;
            bus_req_q  <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            bo_cnt_q <= bo_cnt_q + BO_W'(1);
          end
        end

        S_GRANT: begin
          // The owner's request may drop here; the transfer is already on the bus.
          if (bus_ack) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            src_done_q <= owner_onehot;
            rr_ptr_q   <= rr_ptr_d;
`ifdef ACK_TIMEOUT_EN
          end else if (ack_cnt_q == ACK_LAST) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            src_err_q <= owner_onehot;
            rr_ptr_q  <= rr_ptr_d;
          end else begin
            ack_cnt_q <= ack_cnt_q + ACK_W'(1);
`endif
          end
        end

        default: begin
          state_q   <= S_IDLE;
          bus_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req  = bus_req_q;
  assign src_done = src_done_q;
  assign src_err  = src_err_q;
  assign owner_id = owner_q;
  assign busy     = busy_q;

  // Completion pulses are exclusive and name at most one source.
  a_done_err_excl: assert property (@(posedge clk) disable iff (!reset_n) !((|src_done_q) && (|src_err_q)));
  a_done_onehot:   assert property (@(posedge clk) disable iff (!reset_n) $onehot0(src_done_q));
  a_err_onehot:    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(src_err_q));

endmodule
